// File: rtl/exc_arbiter.sv
// ---------------------------------------------------------------------------
// exc_arbiter
// Exception arbiter and flush controller at the MEM/WB boundary. It collects
// the MEM instruction's exception candidates and the cp0 interrupt request,
// picks one by MIPS priority, and commits it to cp0. It also raises the
// pipeline flush and the fetch redirect, which goes to the handler vector
// or to EPC for ERET.
//
// Optional feature: define EXC_CNT_EN to build a saturating 16-bit count of
// committed exceptions, with ERET not counted. When it is undefined,
// exc_cnt_o is tied to 0.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   mem_valid_i        MEM slot holds a real instruction
//   mem_stall_i        MEM stage stalled
//   mem_pc_i           PC of the MEM instruction
//   mem_inslot_i       MEM instruction sits in a delay slot
//   mem_exc_vec_i      candidates [0]AdEL1 [1]RI [2]Ov [3]SysC [4]Bp
//                      [5]AdEL2 [6]AdES [7]ERET [8]reserved
//   mem_iaddr_i        faulting fetch address
//   mem_daddr_i        faulting data address
//   intr_i             interrupt request from cp0
//   status_bev_i       Status.BEV
//   epc_i              EPC from cp0
//   cp0_exc_flag_o     one-cycle commit pulse to cp0
//   cp0_exc_type_o     committed type (1 Intr .. 9 ERET, 0 none)
//   cp0_pc_o           PC of the committed instruction
//   cp0_baddr_o        bad address for address-error types
//   cp0_inslot_o       delay-slot flag of the committed instruction
//   flush_o            flush every stage up to and including MEM
//   redirect_o         one-cycle pulse, fetch restarts at redirect_pc_o
//   redirect_pc_o      restart address
//   exc_cnt_o          committed-exception count
// ---------------------------------------------------------------------------
module exc_arbiter #(
  parameter int          FLUSH_CYC = 2,
  parameter logic [31:0] VEC_BEV1  = 32'hBFC00380,
  parameter logic [31:0] VEC_BEV0  = 32'h80000180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid_i,
  input  logic        mem_stall_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_inslot_i,
  input  logic [8:0]  mem_exc_vec_i,
  input  logic [31:0] mem_iaddr_i,
  input  logic [31:0] mem_daddr_i,
  input  logic        intr_i,
  input  logic        status_bev_i,
  input  logic [31:0] epc_i,
  output logic        cp0_exc_flag_o,
  output logic [3:0]  cp0_exc_type_o,
  output logic [31:0] cp0_pc_o,
  output logic [31:0] cp0_baddr_o,
  output logic        cp0_inslot_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic [15:0] exc_cnt_o
);

  localparam logic [3:0] T_NONE  = 4'd0;
  localparam logic [3:0] T_INTR  = 4'd1;
  localparam logic [3:0] T_ADEL1 = 4'd2;
  localparam logic [3:0] T_ADEL2 = 4'd3;
  localparam logic [3:0] T_ADES  = 4'd4;
  localparam logic [3:0] T_OV    = 4'd5;
  localparam logic [3:0] T_SYSC  = 4'd6;
  localparam logic [3:0] T_BP    = 4'd7;
  localparam logic [3:0] T_RI    = 4'd8;
  localparam logic [3:0] T_ERET  = 4'd9;

  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_FLUSH} state_t;

  // Priority encoder: Intr > AdEL1 > RI > Ov > SysC > Bp > AdEL2 > AdES > ERET.
  // Bit 8 of the candidate vector is reserved and never selects a type.
  function automatic logic [3:0] sel_type(input logic [8:0] vec, input logic intr);
    logic [3:0] t;
    t = T_NONE;
    if (intr)        t = T_INTR;
    else if (vec[0]) t = T_ADEL1;
    else if (vec[1]) t = T_RI;
    else if (vec[2]) t = T_OV;
    else if (vec[3]) t = T_SYSC;
    else if (vec[4]) t = T_BP;
    else if (vec[5]) t = T_ADEL2;
    else if (vec[6]) t = T_ADES;
    else if (vec[7]) t = T_ERET;
    return t;
  endfunction

  function automatic logic [31:0] sel_baddr(input logic [3:0] t,
                                            input logic [31:0] iaddr,
                                            input logic [31:0] daddr);
    logic [31:0] a;
    case (t)
      T_ADEL1:        a = iaddr;
      T_ADEL2, T_ADES: a = daddr;
      default:        a = 32'h0;
    endcase
    return a;
  endfunction

  state_t      r_state;
  logic [2:0]  r_fcnt;
  logic        r_intr_pend;

  logic        w_intr;
  logic        w_cand;
  logic        w_commit;
  logic [3:0]  w_type;
  logic [31:0] w_baddr;
  logic [31:0] w_rpc;

  // A pending interrupt only rides on a real instruction. Candidates
  // offered while flushing belong to squashed instructions and are dropped.
  assign w_intr   = r_intr_pend | intr_i;
  assign w_cand   = mem_valid_i & ((|mem_exc_vec_i[7:0]) | w_intr);
  assign w_commit = (r_state != S_FLUSH) & w_cand & ~mem_stall_i;
  assign w_type   = sel_type(mem_exc_vec_i, w_intr);
  assign w_baddr  = sel_baddr(w_type, mem_iaddr_i, mem_daddr_i);
  assign w_rpc    = (w_type == T_ERET) ? epc_i :
                    (status_bev_i ? VEC_BEV1 : VEC_BEV0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_fcnt         <= 3'd0;
      r_intr_pend    <= 1'b0;
      cp0_exc_flag_o <= 1'b0;
      cp0_exc_type_o <= T_NONE;
      cp0_pc_o       <= 32'h0;
      cp0_baddr_o    <= 32'h0;
      cp0_inslot_o   <= 1'b0;
      flush_o        <= 1'b0;
      redirect_o     <= 1'b0;
      redirect_pc_o  <= 32'h0;
    end else begin
      // Commit payload is presented only alongside the commit pulse.
      cp0_exc_flag_o <= w_commit;
      redirect_o     <= w_commit;
      cp0_exc_type_o <= w_commit ? w_type       : T_NONE;
      cp0_pc_o       <= w_commit ? mem_pc_i     : 32'h0;
      cp0_baddr_o    <= w_commit ? w_baddr      : 32'h0;
      cp0_inslot_o   <= w_commit ? mem_inslot_i : 1'b0;
      redirect_pc_o  <= w_commit ? w_rpc        : 32'h0;

      // Interrupt latch: consumed by an Intr commit, forgotten as soon as
      // cp0 withdraws the request, otherwise remembered across bubbles/stalls.
      if (w_commit && (w_type == T_INTR)) r_intr_pend <= 1'b0;
      else if (!intr_i)                   r_intr_pend <= 1'b0;
      else                                r_intr_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_commit) begin
            r_state <= S_FLUSH;
            r_fcnt  <= FCNT_INIT;
            flush_o <= 1'b1;
          end else if (w_cand) begin
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Inputs are re-evaluated live; the stalled instruction may vanish.
          if (w_commit) begin
            r_state <= S_FLUSH;
            r_fcnt  <= FCNT_INIT;
            flush_o <= 1'b1;
          end else if (!w_cand) begin
            r_state <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (r_fcnt == 3'd0) begin
            r_state <= S_IDLE;
            flush_o <= 1'b0;
          end else begin
            r_fcnt <= r_fcnt - 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_CNT_EN
  logic [15:0] r_exc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exc_cnt <= 16'h0;
    end else if (w_commit && (w_type != T_ERET) && (r_exc_cnt != 16'hFFFF)) begin
      r_exc_cnt <= r_exc_cnt + 16'd1;
    end
  end

  assign exc_cnt_o = r_exc_cnt;
`else
  assign exc_cnt_o = 16'h0;
`endif

endmodule

// File: doc/exc_arbiter.md
Name: exc_arbiter

Overview:
- Exception arbiter and flush controller at the MEM/WB boundary, directly upstream of the cp0 register file.
- Collects per-instruction exception candidates plus the cp0 interrupt request, selects one by MIPS priority and commits it to cp0 as flag/type/pc/baddr/inslot.
- Drives the pipeline flush and the redirect PC: exception vector, or EPC for ERET.
- Handles MEM stalls and holds a pending interrupt until a valid instruction is available to carry it.

Parameters:
- FLUSH_CYC, 2, cycles flush_o stays high per committed exception (1..7).
- VEC_BEV1, 32'hBFC00380, handler vector when Status.BEV=1.
- VEC_BEV0, 32'h80000180, handler vector when Status.BEV=0.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_valid_i  in  1  MEM-stage slot holds a real instruction
- mem_stall_i  in  1  MEM stage stalled (for example, a data cache miss)
- mem_pc_i  in  32  PC of the MEM instruction
- mem_inslot_i  in  1  MEM instruction is in a delay slot
- mem_exc_vec_i  in  9  candidate bits: [0]AdEL1(fetch) [1]RI [2]Ov [3]SysC [4]Bp [5]AdEL2(load) [6]AdES [7]ERET [8]reserved (ignored)
- mem_iaddr_i  in  32  faulting fetch address
- mem_daddr_i  in  32  faulting data address
- intr_i  in  1  exc_intr from cp0
- status_bev_i  in  1  Status.BEV
- epc_i  in  32  EPC from cp0
- cp0_exc_flag_o  out  1  commit pulse to cp0
- cp0_exc_type_o  out  4  1 Intr, 2 AdEL1, 3 AdEL2, 4 AdES, 5 Ov, 6 SysC, 7 Bp, 8 RI, 9 ERET, 0 none
- cp0_pc_o  out  32  instruction PC
- cp0_baddr_o  out  32  bad address
- cp0_inslot_o  out  1  delay-slot flag
- flush_o  out  1  flush all stages up to and including MEM
- redirect_o  out  1  one-cycle pulse, fetch restarts at redirect_pc_o
- redirect_pc_o  out  32  restart address
- exc_cnt_o  out  16  committed-exception count (see Optional Feature)

Behaviour:
- Reset: every output is 0; state IDLE; intr_pend=0.
- States:
  - IDLE: a candidate exists when mem_valid_i & (|mem_exc_vec_i[7:0] | intr_pend | intr_i).
    - Candidate and !mem_stall_i: register the commit and go to FLUSH.
    - Candidate and mem_stall_i: go to HOLD.
  - HOLD: re-evaluate the inputs every cycle, using current values, with no latching. Commit on the first cycle where !mem_stall_i, then go to FLUSH. If mem_valid_i drops, return to IDLE.
  - FLUSH: hold flush_o=1 for FLUSH_CYC cycles, then return to IDLE. New candidates are ignored in this state; flushed instructions are invalid anyway.
- Commit timing: all outputs are registered. The commit cycle is edge N. On edge N+1:
  - cp0_exc_flag_o=1 and redirect_o=1 for exactly one cycle.
  - flush_o rises and stays high for FLUSH_CYC cycles.
- Priority, highest first: Intr > AdEL1 > RI > Ov > SysC > Bp > AdEL2 > AdES > ERET.
- baddr selection:
  - AdEL1: mem_iaddr_i.
  - AdEL2 / AdES: mem_daddr_i.
  - All other types: 0.
- redirect_pc_o:
  - ERET: epc_i, sampled in the commit cycle.
  - All other types: VEC_BEV1 if status_bev_i=1, else VEC_BEV0.
- cp0_pc_o = mem_pc_i and cp0_inslot_o = mem_inslot_i. cp0 applies the -4 for delay-slot instructions.
- Interrupt latch:
  - intr_pend is set when intr_i=1 and no commit happens that cycle (for example, a bubble or a stall).
  - intr_pend is cleared when an Intr commit occurs.
  - intr_pend is also cleared when intr_i drops while the latch is not yet committed, so a masked or acked interrupt is not taken.
- Simultaneous events: an interrupt and a synchronous exception on the same instruction commit Intr only. A candidate arriving in the same cycle FLUSH ends is evaluated on the next cycle in IDLE.
- Reset mid-FLUSH or mid-HOLD: immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro EXC_CNT_EN.
- Defined: exc_cnt_o is a 16-bit counter that increments on every cp0_exc_flag_o pulse, ERET excluded, and saturates at 16'hFFFF. Reset value 0.
- Undefined: exc_cnt_o is tied to 0 and no counter logic is generated.

Test Plan:
- Ov on pc=0x8000_0100, BEV=1, no stall -> the next cycle shows exc_flag=1, type=5, pc=0x8000_0100, redirect_pc=0xBFC00380; flush_o high for 2 cycles.
- AdEL2, daddr=0x0000_0003, BEV=0, stall held 3 cycles -> no commit while stalled; on the cycle after the stall drops, type=3, baddr=0x3, redirect_pc=0x80000180.
- intr_i=1 on a bubble (mem_valid=0), followed by a valid SysC -> that instruction commits type=1 (Intr only), and intr_pend clears.
- ERET, epc_i=0xBFC0_0500 -> type=9, redirect_pc=0xBFC00500; exc_cnt_o is unchanged when EXC_CNT_EN is defined.
- AdEL1+RI+Bp on an inslot instruction -> type=2, baddr=mem_iaddr_i, inslot=1. A second exception offered during FLUSH is ignored.
- rst_n pulsed low during FLUSH -> flush_o and all other outputs drop to 0 immediately; normal operation resumes after reset deasserts.
